// File: rtl/down_counter_ld_pkg.sv
// down_counter_ld_pkg
// Shared definitions for the ROMix iteration counters: the default counter
// width (so the up and down counters agree on N), the down counter's state
// encoding, and a small helper used when a new count is loaded.
// Optional feature macro used by down_counter_ld: DOWN_COUNTER_LD_AUTORELOAD_EN.

package down_counter_ld_pkg;

    // Width shared with the free-running up counter; N = 2**DEFAULT_SIZE.
    localparam int DEFAULT_SIZE = 5;

    // Raw state codes; 2'd3 is unused and treated as illegal.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        COUNT = ST_COUNT,
        DONE  = ST_DONE
    } state_t;

    // A zero-length run finishes immediately; anything else starts counting.
    function automatic state_t load_target(input logic load_is_zero);
        return load_is_zero ? DONE : COUNT;
    endfunction

endpackage

// File: rtl/down_counter_ld_if.sv
// down_counter_ld_if
// Control/status bundle between the ROMix controller (master) and the
// iteration down counter (slave). Clock and reset are kept as plain ports
// on the modules.

interface down_counter_ld_if #(
    parameter int SIZE = down_counter_ld_pkg::DEFAULT_SIZE
);

    logic            load;
    logic [SIZE-1:0] load_val;
    logic            en;
    logic [SIZE-1:0] out;
    logic            zero;
    logic            busy;
    logic            done;

    // Controller side: issues loads and decrement requests, watches status.
    modport master (
        output load,
        output load_val,
        output en,
        input  out,
        input  zero,
        input  busy,
        input  done
    );

    // Counter side.
    modport slave (
        input  load,
        input  load_val,
        input  en,
        output out,
        output zero,
        output busy,
        output done
    );

endinterface

// File: rtl/down_counter_ld.sv
// down_counter_ld
// Loadable down counter that tracks the remaining iterations of the ROMix
// read/mix pass. A load starts a run, each en steps the count down by one,
// and reaching zero produces a single registered done pulse. The count never
// wraps below zero. A load always wins over en in the same cycle, and a load
// during a run restarts it without a done pulse.
//
// Optional feature: define DOWN_COUNTER_LD_AUTORELOAD_EN to keep a shadow copy
// of the last loaded value and reload it at terminal count instead of
// stopping; done then pulses once per period while busy stays high, and only
// a load of zero (or reset) ends the run.

module down_counter_ld
    import down_counter_ld_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic              clk,
    input  logic              RST_N,
    down_counter_ld_if.slave  bus
);

    localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

    state_t          state_q;
    logic [SIZE-1:0] count_q;

`ifdef DOWN_COUNTER_LD_AUTORELOAD_EN
    logic [SIZE-1:0] shadow_q;
    logic            reload_pulse_q;

    // Remember the most recent load value so a finished period can restart.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            shadow_q <= '0;
        end else if (bus.load) begin
            shadow_q <= bus.load_val;
        end
    end
`endif

    // State and count update: load first, then decrement, then hold.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            count_q <= '0;
`ifdef DOWN_COUNTER_LD_AUTORELOAD_EN
            reload_pulse_q <= 1'b0;
`endif
        end else begin
`ifdef DOWN_COUNTER_LD_AUTORELOAD_EN
            reload_pulse_q <= 1'b0;
`endif
            case (state_q)
                IDLE, DONE: begin
                    if (bus.load) begin
                        count_q <= bus.load_val;
                        state_q <= load_target(bus.load_val == '0);
                    end else begin
                        state_q <= IDLE;
                    end
                end

                COUNT: begin
                    if (bus.load) begin
                        count_q <= bus.load_val;
                        state_q <= load_target(bus.load_val == '0);
                    end else if (bus.en && (count_q != '0)) begin
                        if (count_q == ONE) begin
`ifdef DOWN_COUNTER_LD_AUTORELOAD_EN
                            count_q        <= shadow_q;
                            reload_pulse_q <= 1'b1;
`else
                            count_q <= '0;
                            state_q <= DONE;
`endif
                        end else begin
                            count_q <= count_q - ONE;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    // Status decoded straight from registers so it is glitch-free.
    assign bus.out  = count_q;
    assign bus.zero = (count_q == '0);
    assign bus.busy = (state_q == COUNT);
`ifdef DOWN_COUNTER_LD_AUTORELOAD_EN
    assign bus.done = (state_q == DONE) || reload_pulse_q;
`else
    assign bus.done = (state_q == DONE);
`endif

endmodule

// File: tb/tb_down_counter_ld.sv
// tb_down_counter_ld
// Directed bench for down_counter_ld. A behavioural model of the counter's
// rules runs alongside the DUT and is compared every cycle; hand-computed
// literal checks pin the model at key points of each scenario.
// Honours DOWN_COUNTER_LD_AUTORELOAD_EN when the design is built with it.

module tb_down_counter_ld;

    localparam int SIZE = 5;

    logic clk;
    logic rst_n;

    down_counter_ld_if #(.SIZE(SIZE)) dut_if ();

    down_counter_ld #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .RST_N (rst_n),
        .bus   (dut_if.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 0;

    // Model state: value on out, whether a run is active, and the done pulse.
    int exp_out     = 0;
    bit exp_running = 0;
    bit exp_done    = 0;
    int exp_shadow  = 0;

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic model_reset();
        exp_out     = 0;
        exp_running = 0;
        exp_done    = 0;
        exp_shadow  = 0;
    endtask

    // One clock edge of the counter's rules, in terms of remaining iterations.
    task automatic model_step();
        exp_done = 0;
        if (dut_if.load) begin
            exp_out    = int'(dut_if.load_val);
            exp_shadow = exp_out;
            if (exp_out == 0) begin
                exp_running = 0;
                exp_done    = 1;
            end else begin
                exp_running = 1;
            end
        end else if (exp_running && dut_if.en && exp_out > 0) begin
            exp_out = exp_out - 1;
            if (exp_out == 0) begin
`ifdef DOWN_COUNTER_LD_AUTORELOAD_EN
                exp_out  = exp_shadow;
                exp_done = 1;
`else
                exp_running = 0;
                exp_done    = 1;
`endif
            end
        end
    endtask

    // Every clock edge or reset assertion: advance the model, then compare.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
            #1;
            if (check_en) begin
                cmp("model_out",  int'(dut_if.out),  exp_out);
                cmp("model_zero", int'(dut_if.zero), (exp_out == 0) ? 1 : 0);
                cmp("model_busy", int'(dut_if.busy), int'(exp_running));
                cmp("model_done", int'(dut_if.done), int'(exp_done));
            end
        end
    end

    // Drive one cycle of inputs at the falling edge, settle past the next rise.
    task automatic apply_stimulus(input logic ld, input int val, input logic e);
        @(negedge clk);
        dut_if.load     = ld;
        dut_if.load_val = val[SIZE-1:0];
        dut_if.en       = e;
        @(posedge clk);
        #2;
    endtask

    task automatic check_output(input string name, input int o, input int b, input int d);
        cmp({name, "_out"},  int'(dut_if.out),  o);
        cmp({name, "_zero"}, int'(dut_if.zero), (o == 0) ? 1 : 0);
        cmp({name, "_busy"}, int'(dut_if.busy), b);
        cmp({name, "_done"}, int'(dut_if.done), d);
    endtask

    // Directed scenarios.
    initial begin
        dut_if.load     = 1'b0;
        dut_if.load_val = '0;
        dut_if.en       = 1'b0;
        rst_n           = 1'b0;
        #1;
        check_en = 1;
        #12;
        check_output("reset", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic run: load 5, then en held high down to terminal count.
        apply_stimulus(1, 5, 0);
        check_output("basic_load", 5, 1, 0);
        apply_stimulus(0, 0, 1);
        check_output("basic_4", 4, 1, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 1);
        check_output("basic_1", 1, 1, 0);
        apply_stimulus(0, 0, 1);
`ifndef DOWN_COUNTER_LD_AUTORELOAD_EN
        check_output("basic_0", 0, 0, 1);
        apply_stimulus(0, 0, 1);
        check_output("basic_after", 0, 0, 0);
`endif

        // Priority and gapped en: load with en wins, then 2, hold, 1, reload 7.
        apply_stimulus(1, 3, 1);
        check_output("prio_load", 3, 1, 0);
        apply_stimulus(0, 0, 1);
        apply_stimulus(0, 0, 0);
        check_output("prio_hold", 2, 1, 0);
        apply_stimulus(0, 0, 1);
        check_output("prio_1", 1, 1, 0);
        apply_stimulus(1, 7, 1);
        check_output("reload7", 7, 1, 0);

        // Zero load: immediate done, never busy, no wrap in idle.
        apply_stimulus(1, 0, 0);
        check_output("zero_load", 0, 0, 1);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 1);
        check_output("no_wrap", 0, 0, 0);

`ifndef DOWN_COUNTER_LD_AUTORELOAD_EN
        // Full scale: 31 decrements to done.
        apply_stimulus(1, 31, 0);
        check_output("full_load", 31, 1, 0);
        for (int i = 0; i < 30; i++) apply_stimulus(0, 0, 1);
        check_output("full_1", 1, 1, 0);
        apply_stimulus(0, 0, 1);
        check_output("full_0", 0, 0, 1);
        apply_stimulus(0, 0, 0);
        check_output("full_after", 0, 0, 0);
`endif

        // Reset mid-run at out=10: cleared before the next edge, no done.
        apply_stimulus(1, 31, 0);
        for (int i = 0; i < 21; i++) apply_stimulus(0, 0, 1);
        check_output("pre_reset", 10, 1, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #2;
        check_output("async_reset", 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(0, 0, 1);
        check_output("post_reset", 0, 0, 0);

`ifdef DOWN_COUNTER_LD_AUTORELOAD_EN
        // Autoreload: period of 2 with done on each reload, stop with load 0.
        apply_stimulus(1, 2, 0);
        check_output("ar_load", 2, 1, 0);
        apply_stimulus(0, 0, 1);
        check_output("ar_1", 1, 1, 0);
        apply_stimulus(0, 0, 1);
        check_output("ar_reload", 2, 1, 1);
        apply_stimulus(0, 0, 1);
        check_output("ar_1b", 1, 1, 0);
        apply_stimulus(0, 0, 1);
        check_output("ar_reload_b", 2, 1, 1);
        apply_stimulus(1, 0, 1);
        check_output("ar_stop", 0, 0, 1);
        apply_stimulus(0, 0, 0);
        check_output("ar_idle", 0, 0, 0);
`endif

        apply_stimulus(0, 0, 0);
        check_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/down_counter_ld.md
Name: down_counter_ld

Overview:
- Loadable down counter with terminal-count detection and a one-cycle done pulse.
- Counterpart to the free-running up counter. The up counter indexes the ROMix write pass; this block counts remaining iterations in the ROMix read/mix pass, from N-1 down to 0.
- Controller loads an iteration count, pulses en once per completed iteration, and waits for done.

Parameters:
- SIZE, 5, counter width in bits; max loadable value 2^SIZE-1.

Ports:
- clk  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- load  input  1  load load_val into counter; start a count run.
- load_val  input  SIZE  value captured when load=1.
- en  input  1  decrement request; one step per cycle.
- out  output  SIZE  current count (registered).
- zero  output  1  out == 0 (combinational from register).
- busy  output  1  high while in COUNT state.
- done  output  1  registered one-cycle pulse at terminal count.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (RST_N), asserted on RST_N==0 regardless of clk.
- Reset values:
  - out=0, so zero=1.
  - busy=0, done=0.
  - state=IDLE.
- States:
  - IDLE: waiting for a load.
  - COUNT: counting down.
  - DONE: single-cycle terminal state.
- IDLE transitions:
  - load=1, load_val!=0: out<=load_val, next COUNT.
  - load=1, load_val==0: out<=0, next DONE.
  - en is ignored; out holds.
- COUNT transitions:
  - en=1, out>1: out<=out-1, stay in COUNT.
  - en=1, out==1: out<=0, next DONE.
  - en=0: hold.
- DONE: done=1 for exactly this cycle; next IDLE unconditionally, unless load=1 (then treated as a load from IDLE).
- Latency: done rises one cycle after the clock edge that makes out 0. A load of value V followed by V consecutive en cycles gives done in the cycle after the V-th en edge.
- busy = (state==COUNT); done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- load and en in the same cycle: load wins; en is discarded.
- load during COUNT: restarts with the new load_val and does not pulse done.
- No wrap-around: out never decrements below 0; en at out==0 in any state has no effect.
- Arithmetic: decrement is SIZE-bit unsigned and never underflows, because of the rule above. load_val is taken at full width with no truncation.
- Reset mid-run: immediate return to reset values, with no done pulse.

Optional Feature:
- Macro: DOWN_COUNTER_LD_AUTORELOAD_EN.
- Defined:
  - A SIZE-bit shadow register (reset 0) captures load_val on every load.
  - In COUNT, en at out==1 reloads out<=shadow and stays in COUNT; done pulses one cycle coincident with the reload, and busy stays 1.
  - The run stops only on load with load_val==0 (goes to DONE then IDLE) or on reset.
- Undefined: no shadow register; behaviour exactly as above.

Decomposition:
- Shared package/include holds:
  - state encoding localparams: IDLE=2'd0, COUNT=2'd1, DONE=2'd2; value 2'd3 is illegal and recovers to IDLE.
  - default SIZE constant shared with the up counter so both agree on N.
- No sub-module needed; a single always block for state/count plus assigns.

Test Plan:
- Reset: RST_N=0 asynchronously mid-cycle -> out=0, zero=1, busy=0, done=0 immediately, before the next clk edge.
- Basic run: load=1, load_val=5, then en held high -> out 5,4,3,2,1,0 on consecutive edges; done=1 for exactly one cycle after out reaches 0; busy=1 over those five cycles.
- Gapped en and priority: load_val=3, en pattern 1,0,1 with load=1 and en=1 in the same cycle as the first edge -> load wins, out=3; then 2, hold 2, 1. A re-load of 7 at out=1 restarts at 7 with no done pulse.
- Zero and underflow: load_val=0 -> done pulse next cycle, busy never 1. Then en=1 for 4 cycles in IDLE -> out stays 0, no wrap to 31.
- Full-scale: SIZE=5, load_val=31, 31 en cycles -> done after exactly 31 decrements. Reset asserted at out=10 -> out=0, no done.
- Autoreload, with DOWN_COUNTER_LD_AUTORELOAD_EN defined: load_val=2, en held high -> out 2,1,2,1,..., done pulses every 2 cycles, busy stays 1. Load of 0 -> single done, then IDLE.
